// File: rtl/addsub_serial_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder/subtractor.
// The master side issues operand requests and consumes results; the slave side is the block.
interface addsub_serial_ctrl_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, res, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, res, cout, ovf
   );
endinterface

// File: rtl/addsub_serial_ctrl.sv
// WIDTH-bit two's-complement add/sub computed one nibble per cycle, LSB nibble first.
// Optional macro ADDSUB_SAT_EN clamps an overflowing result to the signed limit of A's sign.
module addsub_serial_ctrl #(
   parameter int WIDTH = 16
) (
   input logic                clk,
   input logic                rst,
   addsub_serial_ctrl_if.slave bus
);
   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = $clog2(NIB);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opA_q, opA_d;
   logic [WIDTH-1:0] opB_q, opB_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             sub_q, sub_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [IDXW-1:0]  idx_q, idx_d;

   logic [3:0]       aNib;
   logic [3:0]       bNib;
   logic [4:0]       nibSum;
   logic             c3;
`ifdef ADDSUB_SAT_EN
   logic [WIDTH-1:0] satVal;
`endif

   // The 4-bit slice; c3 is recovered from sum bit 3 since s3 = a3 ^ b3 ^ c3.
   always_comb begin
      aNib   = opA_q[{idx_q, 2'b00} +: 4];
      bNib   = opB_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};
      nibSum = {1'b0, aNib} + {1'b0, bNib} + {4'b0000, carry_q};
      c3     = nibSum[3] ^ aNib[3] ^ bNib[3];
`ifdef ADDSUB_SAT_EN
      satVal = opA_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
   end

   always_comb begin
      state_d = state_q;
      opA_d   = opA_q;
      opB_d   = opB_q;
      sub_d   = sub_q;
      res_d   = res_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               opA_d   = bus.a;
               opB_d   = bus.b;
               sub_d   = bus.sub;
               carry_d = bus.sub;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d[{idx_q, 2'b00} +: 4] = nibSum[3:0];
            carry_d = nibSum[4];
            if (idx_q == IDXW'(NIB - 1)) begin
               cout_d  = nibSum[4];
               ovf_d   = c3 ^ nibSum[4];
`ifdef ADDSUB_SAT_EN
               if (c3 ^ nibSum[4]) begin
                  res_d = satVal;
               end
`endif
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         opA_q   <= '0;
         opB_q   <= '0;
         sub_q   <= 1'b0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         opA_q   <= opA_d;
         opB_q   <= opB_d;
         sub_q   <= sub_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.res       = res_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
endmodule
